// File: rtl/wb_port_arbiter.sv
// Shares the GPR write port between the in-order writeback stage and out-of-band
// multicycle results, which wait in a small FIFO and drain into idle writeback slots.
module wb_port_arbiter #(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pipe_regWr,
    input  logic [4:0]  pipe_rd,
    input  logic [31:0] pipe_data,
    input  logic        mc_valid,
    input  logic [4:0]  mc_rd,
    input  logic [31:0] mc_data,
    output logic        mc_ready,
    input  logic [4:0]  chk_rd,
    output logic        chk_hit,
    output logic        wr_en,
    output logic [4:0]  wr_addr,
    output logic [31:0] wr_data,
    output logic        pipe_stall,
    output logic        busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    logic [4:0]    fifoRd   [DEPTH];
    logic [31:0]   fifoData [DEPTH];
    logic [AW:0]   wrPtr;
    logic [AW:0]   rdPtr;
    logic [AW:0]   occupancy;
    logic [SW-1:0] starveCnt;

    logic          fifoEmpty;
    logic          fifoFull;
    logic          preq;
    logic          forceDrain;
    logic          grantPipe;
    logic          grantFifo;
    logic          enq;
    logic          fifoHit;
    logic [AW-1:0] offset;

    // Handshake: a multicycle transfer happens on any cycle where mc_valid && mc_ready;
    // mc_ready reflects current occupancy only (never the same-cycle dequeue), and a
    // transfer with mc_rd == 0 is consumed without being stored.
    assign fifoEmpty = (wrPtr == rdPtr);
    assign fifoFull  = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
    assign occupancy = wrPtr - rdPtr;
    assign mc_ready  = !fifoFull;
    assign busy      = !fifoEmpty;
    assign enq       = mc_valid && mc_ready && (mc_rd != 5'd0);

    assign preq       = pipe_regWr && (pipe_rd != 5'd0);
    assign forceDrain = (starveCnt == STARVE_LIM) && !fifoEmpty;
    assign grantFifo  = !fifoEmpty && (forceDrain || !preq);
    assign grantPipe  = preq && !forceDrain;
    assign pipe_stall = preq && !grantPipe;

    // Only entries between the read and write pointers count as pending.
    always_comb begin
        fifoHit = 1'b0;
        offset  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offset = AW'(i) - rdPtr[AW-1:0];
            if (({1'b0, offset} < occupancy) && (fifoRd[i] == chk_rd)) begin
                fifoHit = 1'b1;
            end
        end
    end

    assign chk_hit = (chk_rd != 5'd0) && (fifoHit || (wr_en && (wr_addr == chk_rd)));

    always_ff @(posedge clk) begin
        if (enq) begin
            fifoRd[wrPtr[AW-1:0]]   <= mc_rd;
            fifoData[wrPtr[AW-1:0]] <= mc_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr     <= '0;
            rdPtr     <= '0;
            starveCnt <= '0;
            wr_en     <= 1'b0;
            wr_addr   <= 5'd0;
            wr_data   <= 32'd0;
        end else begin
            if (enq) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (grantFifo) begin
                rdPtr <= rdPtr + 1'b1;
            end

            if (fifoEmpty || grantFifo) begin
                starveCnt <= '0;
            end else if (starveCnt != STARVE_LIM) begin
                starveCnt <= starveCnt + 1'b1;
            end

            // Address/data hold their last value on idle cycles; only wr_en drops.
            wr_en <= grantPipe || grantFifo;
            if (grantPipe) begin
                wr_addr <= pipe_rd;
                wr_data <= pipe_data;
            end else if (grantFifo) begin
                wr_addr <= fifoRd[rdPtr[AW-1:0]];
                wr_data <= fifoData[rdPtr[AW-1:0]];
            end
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: inputs change just after the rising edge,
// outputs are sampled on the falling edge.
module tb_wb_port_arbiter;

    logic        clk;
    logic        rst_n;
    logic        pipe_regWr;
    logic [4:0]  pipe_rd;
    logic [31:0] pipe_data;
    logic        mc_valid;
    logic [4:0]  mc_rd;
    logic [31:0] mc_data;
    logic        mc_ready;
    logic [4:0]  chk_rd;
    logic        chk_hit;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        pipe_stall;
    logic        busy;

    int errors = 0;
    int checks = 0;

    logic [36:0] exp_q[$];

    wb_port_arbiter #(.DEPTH(2), .STARVE_MAX(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .pipe_regWr(pipe_regWr), .pipe_rd(pipe_rd), .pipe_data(pipe_data),
        .mc_valid(mc_valid), .mc_rd(mc_rd), .mc_data(mc_data), .mc_ready(mc_ready),
        .chk_rd(chk_rd), .chk_hit(chk_hit),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .pipe_stall(pipe_stall), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        pipe_regWr = 1'b0; pipe_rd = 5'd0; pipe_data = 32'd0;
        mc_valid = 1'b0; mc_rd = 5'd0; mc_data = 32'd0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        chk_rd = 5'd5;
        @(negedge clk);
        checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b expected 0", wr_en); end
        checks++; if (wr_addr !== 5'd0) begin errors++; $display("FAIL reset_wr_addr: got %h expected 0", wr_addr); end
        checks++; if (wr_data !== 32'd0) begin errors++; $display("FAIL reset_wr_data: got %h expected 0", wr_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (mc_ready !== 1'b1) begin errors++; $display("FAIL reset_mc_ready: got %b expected 1", mc_ready); end
        checks++; if (pipe_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", pipe_stall); end
        checks++; if (chk_hit !== 1'b0) begin errors++; $display("FAIL reset_chk_hit: got %b expected 0", chk_hit); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_pipe_write();
        pipe_regWr = 1'b1; pipe_rd = 5'd5; pipe_data = 32'hDEADBEEF;
        chk_rd = 5'd5;
        @(negedge clk);
        checks++; if (pipe_stall !== 1'b0) begin errors++; $display("FAIL pipe_stall: got %b expected 0", pipe_stall); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL pipe_busy: got %b expected 0", busy); end
        tick();
        idle_inputs();
        @(negedge clk);
        checks++; if (wr_en !== 1'b1) begin errors++; $display("FAIL pipe_wr_en: got %b expected 1", wr_en); end
        checks++; if (wr_addr !== 5'd5) begin errors++; $display("FAIL pipe_wr_addr: got %h expected 05", wr_addr); end
        checks++; if (wr_data !== 32'hDEADBEEF) begin errors++; $display("FAIL pipe_wr_data: got %h expected deadbeef", wr_data); end
        checks++; if (chk_hit !== 1'b1) begin errors++; $display("FAIL pipe_chk_hit_outreg: got %b expected 1", chk_hit); end
        tick();
        @(negedge clk);
        checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL pipe_wr_en_drop: got %b expected 0", wr_en); end
        checks++; if (wr_addr !== 5'd5) begin errors++; $display("FAIL pipe_wr_addr_hold: got %h expected 05", wr_addr); end
        checks++; if (chk_hit !== 1'b0) begin errors++; $display("FAIL pipe_chk_hit_clear: got %b expected 0", chk_hit); end
        tick();
    endtask

    task automatic test_mc_single();
        mc_valid = 1'b1; mc_rd = 5'd7; mc_data = 32'h1234;
        chk_rd = 5'd7;
        @(negedge clk);
        checks++; if (mc_ready !== 1'b1) begin errors++; $display("FAIL mc_ready_accept: got %b expected 1", mc_ready); end
        checks++; if (chk_hit !== 1'b0) begin errors++; $display("FAIL mc_chk_hit_before: got %b expected 0", chk_hit); end
        tick();
        idle_inputs();
        @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mc_busy: got %b expected 1", busy); end
        checks++; if (chk_hit !== 1'b1) begin errors++; $display("FAIL mc_chk_hit_fifo: got %b expected 1", chk_hit); end
        checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL mc_no_bypass: got %b expected 0", wr_en); end
        tick();
        @(negedge clk);
        checks++; if (wr_en !== 1'b1) begin errors++; $display("FAIL mc_wr_en: got %b expected 1", wr_en); end
        checks++; if (wr_addr !== 5'd7) begin errors++; $display("FAIL mc_wr_addr: got %h expected 07", wr_addr); end
        checks++; if (wr_data !== 32'h1234) begin errors++; $display("FAIL mc_wr_data: got %h expected 00001234", wr_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mc_busy_clear: got %b expected 0", busy); end
        checks++; if (chk_hit !== 1'b1) begin errors++; $display("FAIL mc_chk_hit_outreg: got %b expected 1", chk_hit); end
        tick();
        @(negedge clk);
        checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL mc_wr_en_drop: got %b expected 0", wr_en); end
        checks++; if (chk_hit !== 1'b0) begin errors++; $display("FAIL mc_chk_hit_end: got %b expected 0", chk_hit); end
        tick();
    endtask

    task automatic test_simultaneous();
        pipe_regWr = 1'b1; pipe_rd = 5'd9; pipe_data = 32'hAAAA;
        mc_valid = 1'b1; mc_rd = 5'd10; mc_data = 32'hBBBB;
        @(negedge clk);
        checks++; if (pipe_stall !== 1'b0) begin errors++; $display("FAIL sim_stall: got %b expected 0", pipe_stall); end
        tick();
        idle_inputs();
        @(negedge clk);
        checks++; if (wr_en !== 1'b1 || wr_addr !== 5'd9 || wr_data !== 32'hAAAA) begin
            errors++; $display("FAIL sim_first_write: got en=%b addr=%h data=%h expected en=1 addr=09 data=0000aaaa", wr_en, wr_addr, wr_data);
        end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL sim_busy: got %b expected 1", busy); end
        tick();
        @(negedge clk);
        checks++; if (wr_en !== 1'b1 || wr_addr !== 5'd10 || wr_data !== 32'hBBBB) begin
            errors++; $display("FAIL sim_second_write: got en=%b addr=%h data=%h expected en=1 addr=0a data=0000bbbb", wr_en, wr_addr, wr_data);
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL sim_busy_clear: got %b expected 0", busy); end
        tick();
        @(negedge clk);
        checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL sim_idle: got %b expected 0", wr_en); end
        tick();
    endtask

    task automatic test_zero_rd();
        pipe_regWr = 1'b1; pipe_rd = 5'd0; pipe_data = 32'h9999;
        mc_valid = 1'b1; mc_rd = 5'd0; mc_data = 32'h8888;
        chk_rd = 5'd0;
        @(negedge clk);
        checks++; if (mc_ready !== 1'b1) begin errors++; $display("FAIL zero_mc_ready: got %b expected 1", mc_ready); end
        checks++; if (pipe_stall !== 1'b0) begin errors++; $display("FAIL zero_stall: got %b expected 0", pipe_stall); end
        tick();
        idle_inputs();
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL zero_busy: got %b expected 0", busy); end
        checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL zero_wr_en: got %b expected 0", wr_en); end
        checks++; if (chk_hit !== 1'b0) begin errors++; $display("FAIL zero_chk_hit: got %b expected 0", chk_hit); end
        tick();
    endtask

    // Three results against continuous writeback traffic: fill, starve, forced drain.
    task automatic test_back_to_back();
        int t_preq [11] = '{1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0};
        int t_pd   [11] = '{0, 1, 2, 3, 4, 5, 5, 0, 0, 0, 0};
        int t_mcv  [11] = '{1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0};
        int t_mcrd [11] = '{1, 2, 3, 3, 3, 3, 3, 0, 0, 0, 0};
        int t_stall[11] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0};
        int t_ready[11] = '{1, 1, 0, 0, 0, 0, 1, 0, 1, 1, 1};
        logic [36:0] exp_item;
        int stall_cycles;
        stall_cycles = 0;
        exp_q.delete();
        exp_q.push_back({5'd20, 32'h5000});
        exp_q.push_back({5'd20, 32'h5001});
        exp_q.push_back({5'd20, 32'h5002});
        exp_q.push_back({5'd20, 32'h5003});
        exp_q.push_back({5'd20, 32'h5004});
        exp_q.push_back({5'd1,  32'h11});
        exp_q.push_back({5'd20, 32'h5005});
        exp_q.push_back({5'd2,  32'h22});
        exp_q.push_back({5'd3,  32'h33});
        chk_rd = 5'd2;
        for (int c = 0; c < 11; c++) begin
            pipe_regWr = (t_preq[c] != 0);
            pipe_rd    = 5'd20;
            pipe_data  = 32'h5000 + 32'(t_pd[c]);
            mc_valid   = (t_mcv[c] != 0);
            mc_rd      = 5'(t_mcrd[c]);
            mc_data    = 32'h11 * 32'(t_mcrd[c]);
            @(negedge clk);
            if (pipe_stall === 1'b1) stall_cycles++;
            checks++; if (pipe_stall !== (t_stall[c] != 0)) begin
                errors++; $display("FAIL b2b_stall c%0d: got %b expected %0d", c, pipe_stall, t_stall[c]);
            end
            checks++; if (mc_ready !== (t_ready[c] != 0)) begin
                errors++; $display("FAIL b2b_mc_ready c%0d: got %b expected %0d", c, mc_ready, t_ready[c]);
            end
            if (c == 3) begin
                checks++; if (chk_hit !== 1'b1) begin errors++; $display("FAIL b2b_chk_hit_fifo: got %b expected 1", chk_hit); end
            end
            if (wr_en === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL b2b_extra_write c%0d: got addr=%h data=%h expected none", c, wr_addr, wr_data);
                end else begin
                    exp_item = exp_q.pop_front();
                    if ({wr_addr, wr_data} !== exp_item) begin
                        errors++; $display("FAIL b2b_write c%0d: got addr=%h data=%h expected addr=%h data=%h",
                                           c, wr_addr, wr_data, exp_item[36:32], exp_item[31:0]);
                    end
                end
            end
            tick();
        end
        idle_inputs();
        @(negedge clk);
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_missing_writes: got %0d left expected 0", exp_q.size()); end
        checks++; if (stall_cycles != 1) begin errors++; $display("FAIL b2b_stall_cycles: got %0d expected 1", stall_cycles); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_end: got %b expected 0", busy); end
        tick();
    endtask

    task automatic test_reset_mid();
        pipe_regWr = 1'b1; pipe_rd = 5'd21; pipe_data = 32'hAA;
        mc_valid = 1'b1; mc_rd = 5'd4; mc_data = 32'h44;
        chk_rd = 5'd4;
        tick();
        mc_rd = 5'd5; mc_data = 32'h55;
        tick();
        @(negedge clk);
        checks++; if (mc_ready !== 1'b0) begin errors++; $display("FAIL rmid_full: got %b expected 0", mc_ready); end
        checks++; if (busy !== 1'b1 || wr_en !== 1'b1) begin
            errors++; $display("FAIL rmid_pre_state: got busy=%b wr_en=%b expected busy=1 wr_en=1", busy, wr_en);
        end
        #1;
        rst_n = 1'b0;
        idle_inputs();
        #1;
        checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL rmid_wr_en: got %b expected 0", wr_en); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b expected 0", busy); end
        checks++; if (mc_ready !== 1'b1) begin errors++; $display("FAIL rmid_mc_ready: got %b expected 1", mc_ready); end
        checks++; if (chk_hit !== 1'b0) begin errors++; $display("FAIL rmid_chk_hit: got %b expected 0", chk_hit); end
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++; if (wr_en !== 1'b0 || busy !== 1'b0) begin
                errors++; $display("FAIL rmid_stale c%0d: got wr_en=%b busy=%b expected 0 0", c, wr_en, busy);
            end
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_pipe_write();
        test_mc_single();
        test_simultaneous();
        test_zero_rd();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Shares the single general-purpose register file write port between the in-order pipeline writeback stage and the long-latency multicycle unit (multiply/divide, FP convert) that returns results out of band. Multicycle results are held in a small FIFO and drained into idle writeback slots. An anti-starvation counter stalls the pipeline when the FIFO has waited too long. The block also exposes a pending-destination lookup so hazard detection can stall dependent instructions.

## Interface
- DEPTH, 2: multicycle result FIFO entries; power of 2, at least 2.
- STARVE_MAX, 4: consecutive cycles a non-empty FIFO may lose arbitration before forced drain; at least 1.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- pipe_regWr  in  1  WB stage requests a GPR write.
- pipe_rd  in  5  WB destination register.
- pipe_data  in  32  WB write data (final regWrData).
- mc_valid  in  1  multicycle unit result valid.
- mc_rd  in  5  multicycle destination register.
- mc_data  in  32  multicycle result.
- mc_ready  out  1  FIFO can accept; equals not full.
- chk_rd  in  5  register number queried by hazard detection.
- chk_hit  out  1  chk_rd is pending in the FIFO or in the output register.
- wr_en  out  1  regfile write enable, registered.
- wr_addr  out  5  regfile write address, registered.
- wr_data  out  32  regfile write data, registered.
- pipe_stall  out  1  WB request not granted; pipeline must hold WB and stages behind it.
- busy  out  1  FIFO non-empty.

## Operation
- Pipeline request valid (preq) = pipe_regWr && pipe_rd != 0.
- A multicycle handshake completes when mc_valid && mc_ready.
  - mc_rd == 0: result is accepted and discarded, not enqueued.
  - Otherwise {mc_rd, mc_data} is enqueued at the tail.
- mc_ready depends only on FIFO occupancy, not on the same-cycle dequeue. When full, mc_ready = 0 even if a dequeue happens that cycle.
- Grant priority each cycle, evaluated in this order:
  - force = (starve_cnt == STARVE_MAX) && FIFO non-empty: grant the FIFO head.
  - Else if preq: grant the pipeline.
  - Else if FIFO non-empty: grant the FIFO head.
  - Else: no grant.
- pipe_stall = preq && not granted. Combinational, asserted the same cycle.
  - While stalled, the pipeline holds pipe_* stable.
  - The request is granted on a later cycle; it is never dropped.
- The granted source is registered into wr_en/wr_addr/wr_data at the next edge. With no grant, wr_en = 0 and wr_addr/wr_data hold their previous values.
- starve_cnt:
  - Cleared when the FIFO is granted or the FIFO is empty.
  - Incremented, saturating at STARVE_MAX, when the FIFO is non-empty and not granted.
- chk_hit = (chk_rd != 0) && (any valid FIFO entry has rd == chk_rd, or (wr_en && wr_addr == chk_rd)). Combinational.
- WAW ordering between FIFO and pipeline is hazard detection's job, using chk_hit. This block does not reorder or merge writes.
- FIFO is in-order. Pointers use log2(DEPTH) bits plus one wrap bit; full/empty come from the wrap-bit comparison.
- Simultaneous enqueue and dequeue on a non-empty, non-full FIFO: occupancy unchanged, both pointers advance.
- Enqueue into an empty FIFO: the entry is eligible for grant the following cycle (no bypass).

## Timing
- Reset (rst_n low, asynchronous) clears:
  - FIFO empty, pointers 0, starve_cnt 0.
  - wr_en = 0, wr_addr = 0, wr_data = 0.
  - Resulting outputs: busy = 0, mc_ready = 1, pipe_stall = 0 (given preq = 0), chk_hit = 0.
- Reset mid-operation discards all FIFO contents and any pending write. Upstream units must be reset concurrently.
- Latencies:
  - Pipeline grant to regfile write: 1 cycle (wr_* valid the cycle after grant).
  - Multicycle accept to earliest write: 2 cycles (enqueue, grant, registered output).
- Maximum FIFO wait under continuous preq: STARVE_MAX cycles of loss, then forced grant. Pipeline stall length per forced drain is 1 cycle per forced entry. starve_cnt restarts from 0 after each grant.
- Output-register entries are covered by chk_hit until wr_en deasserts; the regfile write lands at the edge ending the wr_en cycle.

## Test plan
- Reset then idle; pipe_regWr = 1, rd = 5, data = 0xDEADBEEF, one cycle -> next cycle wr_en = 1, wr_addr = 5, wr_data = 0xDEADBEEF; pipe_stall never asserts; busy = 0.
- FIFO empty, mc_valid with rd = 7, data = 0x1234, pipeline idle -> busy = 1 for one cycle; wr_en = 1, wr_addr = 7 two cycles after accept; chk_rd = 7 gives chk_hit = 1 from the cycle after accept until the wr_en cycle ends.
- DEPTH = 2: three back-to-back mc_valid results with continuous preq -> mc_ready = 0 after two accepts. After STARVE_MAX = 4 lost cycles, pipe_stall = 1 for exactly one cycle and the FIFO head is written; mc_ready reasserts the next cycle.
- Simultaneous preq and mc_valid on a cycle when the FIFO is empty -> pipeline written first; FIFO entry written the following cycle; no stall.
- mc_rd = 0 and pipe_rd = 0 requests -> handshakes complete, busy stays 0, wr_en stays 0, pipe_stall = 0.
- FIFO full, rst_n pulsed low mid-cycle -> wr_en = 0, busy = 0, mc_ready = 1 immediately (asynchronous); no stale writes after release.
